// File: rtl/hilo_div_unit_if.sv
// Execute-stage HI/LO bus: operation request from EX, stall/done and HI/LO back to the pipeline.
interface hilo_div_unit_if;
    logic        op_valid;
    logic [2:0]  hilo_op;
    logic [31:0] alu_y;
    logic [31:0] alu_y_lo;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        stall;
    logic        div_done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport slave (
        input  op_valid, hilo_op, alu_y, alu_y_lo, src_a, src_b, flush,
        output stall, div_done, hi, lo
    );

    modport master (
        output op_valid, hilo_op, alu_y, alu_y_lo, src_a, src_b, flush,
        input  stall, div_done, hi, lo
    );
endinterface

// File: rtl/hilo_div_unit.sv
// HI/LO register block with MULT capture, MTHI/MTLO and a 32-step restoring DIV/DIVU.
// Optional HILO_BYPASS_EN forwards same-cycle HI/LO writes combinationally to hi/lo.
//
// state  | meaning
// S_IDLE | accept MULT/MTHI/MTLO writes or start a division
// S_RUN  | one restoring step per cycle, pipeline stalled
// S_DONE | result committed, div_done pulse, back to idle
module hilo_div_unit #(
    parameter logic [31:0] ZERO_DIV_QUOT = 32'hFFFF_FFFF
) (
    input logic             clk,
    input logic             rst_n,
    hilo_div_unit_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam logic [2:0] OP_MULT = 3'b001;
    localparam logic [2:0] OP_DIV  = 3'b010;
    localparam logic [2:0] OP_DIVU = 3'b011;
    localparam logic [2:0] OP_MTHI = 3'b100;
    localparam logic [2:0] OP_MTLO = 3'b101;

    state_t      state_q, state_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] dvsr_q, dvsr_d;
    logic        qneg_q, qneg_d;
    logic        rneg_q, rneg_d;
    logic [4:0]  cnt_q, cnt_d;

    logic        stall_o;
    logic        done_o;
    logic [32:0] rem_sh;
    logic [32:0] trial;
    logic [31:0] rem_nx;
    logic [31:0] quo_nx;
    logic        is_signed;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic        idle_wr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvsr_q  <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvsr_q  <= dvsr_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            cnt_q   <= cnt_d;
        end
    end

    // Partial remainder needs 33 bits after the shift; trial[32] set means the subtract borrowed.
    always_comb begin
        rem_sh    = {rem_q, quo_q[31]};
        trial     = rem_sh - {1'b0, dvsr_q};
        rem_nx    = trial[32] ? rem_sh[31:0] : trial[31:0];
        quo_nx    = {quo_q[30:0], ~trial[32]};
        is_signed = (bus.hilo_op == OP_DIV);
        a_neg     = is_signed & bus.src_a[31];
        b_neg     = is_signed & bus.src_b[31];
        a_mag     = a_neg ? (~bus.src_a + 32'd1) : bus.src_a;
        b_mag     = b_neg ? (~bus.src_b + 32'd1) : bus.src_b;
    end

    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvsr_d  = dvsr_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        cnt_d   = cnt_q;
        stall_o = 1'b0;
        done_o  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.op_valid && !bus.flush) begin
                    case (bus.hilo_op)
                        OP_MULT: begin
                            hi_d = bus.alu_y;
                            lo_d = bus.alu_y_lo;
                        end
                        OP_MTHI: hi_d = bus.src_a;
                        OP_MTLO: lo_d = bus.src_a;
                        OP_DIV, OP_DIVU: begin
                            stall_o = 1'b1;
                            if (bus.src_b == 32'd0) begin
                                lo_d    = ZERO_DIV_QUOT;
                                hi_d    = bus.src_a;
                                state_d = S_DONE;
                            end else begin
                                rem_d   = '0;
                                quo_d   = a_mag;
                                dvsr_d  = b_mag;
                                qneg_d  = a_neg ^ b_neg;
                                rneg_d  = a_neg;
                                cnt_d   = 5'd31;
                                state_d = S_RUN;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                stall_o = 1'b1;
                if (bus.flush) begin
                    state_d = S_IDLE;
                end else begin
                    rem_d = rem_nx;
                    quo_d = quo_nx;
                    cnt_d = cnt_q - 5'd1;
                    if (cnt_q == 5'd0) begin
                        lo_d    = qneg_q ? (~quo_nx + 32'd1) : quo_nx;
                        hi_d    = rneg_q ? (~rem_nx + 32'd1) : rem_nx;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                done_o  = ~bus.flush;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign idle_wr = (state_q == S_IDLE) && bus.op_valid && !bus.flush;

`ifdef HILO_BYPASS_EN
    always_comb begin
        bus.hi = hi_q;
        bus.lo = lo_q;
        if (idle_wr) begin
            if (bus.hilo_op == OP_MULT) begin
                bus.hi = bus.alu_y;
                bus.lo = bus.alu_y_lo;
            end else if (bus.hilo_op == OP_MTHI) begin
                bus.hi = bus.src_a;
            end else if (bus.hilo_op == OP_MTLO) begin
                bus.lo = bus.src_a;
            end
        end
    end
`else
    logic unused_idle_wr;
    assign unused_idle_wr = idle_wr;
    assign bus.hi = hi_q;
    assign bus.lo = lo_q;
`endif

    assign bus.stall    = stall_o;
    assign bus.div_done = done_o;
endmodule

// File: tb/tb_hilo_div_unit.sv
// Self-checking bench for hilo_div_unit: arithmetic reference model plus directed literal checks.
module tb_hilo_div_unit;
    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    hilo_div_unit_if bus ();

    hilo_div_unit #(.ZERO_DIV_QUOT(32'hFFFF_FFFF)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: register values plus "cycles of divide work left" and a pending result.
    logic [31:0] m_hi, m_lo, p_hi, p_lo;
    int          m_busy;
    bit          m_done;

    function automatic void div_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r);
        longint la, lb, lq, lr;
        if (op == 3'b010) begin
            la = longint'($signed(a));
            lb = longint'($signed(b));
        end else begin
            la = longint'({32'd0, a});
            lb = longint'({32'd0, b});
        end
        lq = la / lb;
        lr = la % lb;
        q  = lq[31:0];
        r  = lr[31:0];
    endfunction

    always @(negedge clk) begin
        logic [31:0] e_hi, e_lo, q, r;
        logic        e_stall, e_done, idle, wr;
        if (!rst_n) begin
            m_hi = '0; m_lo = '0; m_busy = 0; m_done = 0;
        end
        idle    = (m_busy == 0) && !m_done;
        wr      = rst_n && idle && bus.op_valid && !bus.flush;
        e_stall = m_busy > 0 || (wr && (bus.hilo_op == 3'b010 || bus.hilo_op == 3'b011));
        e_done  = rst_n && m_done && !bus.flush;
        e_hi    = m_hi;
        e_lo    = m_lo;
`ifdef HILO_BYPASS_EN
        if (wr && bus.hilo_op == 3'b001) begin e_hi = bus.alu_y; e_lo = bus.alu_y_lo; end
        if (wr && bus.hilo_op == 3'b100) e_hi = bus.src_a;
        if (wr && bus.hilo_op == 3'b101) e_lo = bus.src_a;
`endif
        chk("stall", {31'd0, bus.stall}, {31'd0, e_stall});
        chk("div_done", {31'd0, bus.div_done}, {31'd0, e_done});
        chk("hi", bus.hi, e_hi);
        chk("lo", bus.lo, e_lo);
        if (rst_n) begin
            if (m_done) begin
                m_done = 0;
            end else if (m_busy > 0) begin
                if (bus.flush) m_busy = 0;
                else begin
                    m_busy--;
                    if (m_busy == 0) begin m_hi = p_hi; m_lo = p_lo; m_done = 1; end
                end
            end else if (wr) begin
                case (bus.hilo_op)
                    3'b001: begin m_hi = bus.alu_y; m_lo = bus.alu_y_lo; end
                    3'b100: m_hi = bus.src_a;
                    3'b101: m_lo = bus.src_a;
                    3'b010, 3'b011: begin
                        if (bus.src_b == 0) begin
                            m_lo = 32'hFFFF_FFFF; m_hi = bus.src_a; m_done = 1;
                        end else begin
                            div_ref(bus.hilo_op, bus.src_a, bus.src_b, q, r);
                            p_lo = q; p_hi = r; m_busy = 32;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    task automatic idle_in();
        bus.op_valid = 0; bus.hilo_op = 0; bus.flush = 0;
    endtask

    task automatic run_div(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           output int nst, output logic [31:0] h, output logic [31:0] l);
        bit ok;
        ok = 0; nst = 0; h = 'x; l = 'x;
        @(posedge clk); #1;
        bus.op_valid = 1; bus.hilo_op = op; bus.src_a = a; bus.src_b = b;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (bus.stall) nst++;
            if (bus.div_done) begin h = bus.hi; l = bus.lo; ok = 1; end
            @(posedge clk); #1;
            idle_in();
            if (ok) break;
        end
        chk("div_finished", {31'd0, ok}, 32'd1);
    endtask

    task automatic drive_random();
        int k;
        bus.op_valid = ($urandom_range(0, 3) != 0);
        k = $urandom_range(0, 9);
        bus.hilo_op = (k < 3) ? 3'b010 : (k < 5) ? 3'b011 : 3'($urandom_range(0, 7));
        k = $urandom_range(0, 4);
        bus.src_a = (k == 0) ? 32'h8000_0000 : (k == 1) ? 32'hFFFF_FFFF :
                    (k == 2) ? 32'($urandom_range(0, 200)) : $urandom;
        k = $urandom_range(0, 7);
        bus.src_b = (k == 0) ? 32'd0 : (k == 1) ? 32'hFFFF_FFFF :
                    (k == 2) ? 32'($urandom_range(1, 20)) : $urandom;
        bus.alu_y    = $urandom;
        bus.alu_y_lo = $urandom;
        bus.flush    = ($urandom_range(0, 39) == 0);
    endtask

    initial begin
        int          nst, dn;
        logic [31:0] h, l;
        rst_n = 0;
        bus.alu_y = 0; bus.alu_y_lo = 0; bus.src_a = 0; bus.src_b = 0;
        idle_in();
        #1;
        chk("reset_hi", bus.hi, 32'd0);
        chk("reset_lo", bus.lo, 32'd0);
        chk("reset_stall", {31'd0, bus.stall}, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1;

        run_div(3'b011, 32'd100, 32'd7, nst, h, l);
        chk("divu_stall_cycles", nst, 33);
        chk("divu_lo", l, 32'd14);
        chk("divu_hi", h, 32'd2);
        @(negedge clk);
        chk("divu_done_single", {31'd0, bus.div_done}, 32'd0);

        run_div(3'b010, 32'hFFFF_FFF9, 32'd2, nst, h, l);
        chk("div_neg_lo", l, 32'hFFFF_FFFD);
        chk("div_neg_hi", h, 32'hFFFF_FFFF);

        run_div(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, nst, h, l);
        chk("div_ovf_lo", l, 32'h8000_0000);
        chk("div_ovf_hi", h, 32'd0);

        run_div(3'b011, 32'd5, 32'd0, nst, h, l);
        chk("div0_stall_cycles", nst, 1);
        chk("div0_lo", l, 32'hFFFF_FFFF);
        chk("div0_hi", h, 32'd5);

        @(posedge clk); #1;
        bus.op_valid = 1; bus.hilo_op = 3'b001; bus.alu_y = 32'h1; bus.alu_y_lo = 32'h2;
`ifdef HILO_BYPASS_EN
        #1;
        chk("mult_bypass_hi", bus.hi, 32'h1);
        chk("mult_bypass_lo", bus.lo, 32'h2);
`endif
        @(posedge clk); #1;
        chk("mult_hi", bus.hi, 32'h1);
        chk("mult_lo", bus.lo, 32'h2);
        bus.hilo_op = 3'b101; bus.src_a = 32'hABCD;
`ifdef HILO_BYPASS_EN
        #1;
        chk("mtlo_bypass_lo", bus.lo, 32'hABCD);
`endif
        @(posedge clk); #1;
        idle_in();
        chk("mtlo_lo", bus.lo, 32'hABCD);
        chk("mtlo_hi", bus.hi, 32'h1);

        @(posedge clk); #1;
        bus.op_valid = 1; bus.hilo_op = 3'b011; bus.src_a = 32'd1000; bus.src_b = 32'd3;
        @(posedge clk); #1;
        idle_in();
        repeat (9) @(posedge clk);
        #1 bus.flush = 1;
        @(posedge clk); #1;
        bus.flush = 0;
        @(negedge clk);
        chk("flush_stall", {31'd0, bus.stall}, 32'd0);
        chk("flush_hi", bus.hi, 32'h1);
        chk("flush_lo", bus.lo, 32'hABCD);
        dn = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.div_done) dn++;
        end
        chk("flush_no_done", dn, 0);

        @(posedge clk); #1;
        bus.op_valid = 1; bus.hilo_op = 3'b011; bus.src_a = 32'd77; bus.src_b = 32'd5;
        @(posedge clk); #1;
        idle_in();
        repeat (15) @(posedge clk);
        #1 rst_n = 0;
        #1;
        chk("midrst_hi", bus.hi, 32'd0);
        chk("midrst_lo", bus.lo, 32'd0);
        chk("midrst_stall", {31'd0, bus.stall}, 32'd0);
        chk("midrst_done", {31'd0, bus.div_done}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;

        run_div(3'b011, 32'd9, 32'd4, nst, h, l);
        chk("after_rst_lo", l, 32'd2);
        chk("after_rst_hi", h, 32'd1);

        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            drive_random();
        end
        @(posedge clk); #1;
        idle_in();
        repeat (40) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
